// File: rtl/if_queue.sv
`default_nettype none
// ============================================================================
// Module : if_queue
// Desc   : First-word-fall-through instruction queue between fetch and decode,
//          holding {instr, pc, pcp4} tuples; flush empties it in one cycle.
// Rev    : 1.0  initial release
// ============================================================================
module if_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pcp4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcp4,
  output logic [AW:0]     count
);

  localparam int            c_ew       = 3 * XLEN;
  localparam logic [AW:0]   c_full     = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_zero = '0;
  localparam logic [AW:0]   c_cnt_one  = (AW + 1)'(1);
  localparam logic [AW-1:0] c_ptr_one  = AW'(1);

  logic [c_ew-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [AW:0]     r_count;

  logic            w_push;
  logic            w_pop;
  logic [c_ew-1:0] w_head;

  assign in_ready  = (r_count != c_full);
  assign out_valid = (r_count != c_cnt_zero);
  assign count     = r_count;

  // Flush masks both handshakes so wrong-path traffic never touches state.
  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  assign w_head    = r_mem[r_rp];
  assign out_instr = w_head[3*XLEN-1:2*XLEN];
  assign out_pc    = w_head[2*XLEN-1:XLEN];
  assign out_pcp4  = w_head[XLEN-1:0];

  // Storage is data-only and intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= {in_instr, in_pc, in_pcp4};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + c_ptr_one;
      end
      if (w_pop) begin
        r_rp <= r_rp + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_if_queue
// Desc   : Directed self-checking bench for if_queue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_if_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_pcp4;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pcp4;
  logic [AW:0]     count;

  int n_checks = 0;
  int n_errors = 0;

  if_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_pcp4   (in_pcp4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_pcp4  (out_pcp4),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    in_pcp4  = pc + 32'd4;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    in_pcp4   = '0;

    // Reset state
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    rst = 1'b1;
    tick();

    // Reset then fill
    push_one(32'h0000_0100, 32'd0);
    check("fill_count1", 32'(count), 32'd1);
    check("fill_latency_valid", 32'(out_valid), 32'd1);
    push_one(32'h0000_0100, 32'd4);
    check("fill_count2", 32'(count), 32'd2);
    push_one(32'h0000_0101, 32'd8);
    check("fill_count3", 32'(count), 32'd3);
    push_one(32'h0000_0102, 32'd12);
    check("fill_count4", 32'(count), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_out_instr", out_instr, 32'h0000_0100);
    check("fill_out_pc", out_pc, 32'd0);

    // Drain order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", out_pc, 32'(4 * i));
      check("drain_pcp4", out_pcp4, 32'(4 * i + 4));
      tick();
    end
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);

    // Empty pop is ignored
    out_ready = 1'b1;
    tick();
    check("underflow_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Simultaneous push/pop across pointer wrap
    push_one(32'h0000_0200, 32'd0);
    for (int i = 1; i < 10; i++) begin
      in_valid  = 1'b1;
      in_instr  = 32'h0000_0200 + 32'(i);
      in_pc     = 32'(4 * i);
      in_pcp4   = 32'(4 * i + 4);
      out_ready = 1'b1;
      check("stream_count", 32'(count), 32'd1);
      check("stream_pc", out_pc, 32'(4 * (i - 1)));
      check("stream_instr", out_instr, 32'h0000_0200 + 32'(i - 1));
      tick();
    end
    in_valid = 1'b0;
    check("stream_last_pc", out_pc, 32'd36);
    tick();
    out_ready = 1'b0;
    check("stream_end_count", 32'(count), 32'd0);

    // Full plus pop
    for (int i = 0; i < 4; i++) push_one(32'h0000_0300 + 32'(i), 32'(4 * i));
    in_valid  = 1'b1;
    in_instr  = 32'h0000_0304;
    in_pc     = 32'd16;
    in_pcp4   = 32'd20;
    out_ready = 1'b1;
    check("fullpop_in_ready", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_in_ready_next", 32'(in_ready), 32'd1);
    check("fullpop_head", out_pc, 32'd4);
    tick();
    in_valid = 1'b0;
    check("fullpop_accept_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("fullpop_order", out_pc, 32'(4 * i));
      tick();
    end
    out_ready = 1'b0;
    check("fullpop_empty", 32'(count), 32'd0);

    // Flush discards queued and concurrent entries
    for (int i = 0; i < 3; i++) push_one(32'h0000_0400 + 32'(i), 32'(4 * i));
    check("flush_pre_count", 32'(count), 32'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h0000_0403;
    in_pc     = 32'd12;
    in_pcp4   = 32'd16;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    push_one(32'h0000_0107, 32'd28);
    check("postflush_pc", out_pc, 32'd28);
    check("postflush_pcp4", out_pcp4, 32'd32);
    check("postflush_instr", out_instr, 32'h0000_0107);
    check("postflush_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset mid-stream
    push_one(32'h0000_0500, 32'd40);
    push_one(32'h0000_0501, 32'd44);
    check("async_pre_count", 32'(count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("async_after_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
